// File: rtl/snes_joy_pkg.sv
// Shared types and constants for the SNES controller-port auto-read block.
package snes_joy_pkg;

  // Sequencer phases: idle pass-through, latch pulse, clock-low half,
  // clock-high half, and the one-cycle register commit.
  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LO,
    HI,
    COMMIT
  } joy_state_t;

  // Sixteen bits per pad, so a 4-bit index covers one full read.
  localparam int unsigned BIT_W = 4;

  // Default timing in CPU-cycle enable ticks.
  localparam int unsigned DEF_LATCH_TICKS = 12;
  localparam int unsigned DEF_HALF_TICKS  = 6;

  // Counter width able to hold (max of the two phase lengths) - 1.
  function automatic int unsigned tick_width(input int unsigned a,
                                             input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/joy_shift16.sv
// 16-bit deserialiser for one active-low pad data line. Bits arrive MSB
// first; the working register is copied to the visible register on load.
module joy_shift16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift,
  input  logic        line,
  input  logic        load,
  output logic [15:0] q
);

  logic [15:0] work;

  // Shift in the inverted line so a pressed button reads as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
    end else if (shift) begin
      work <= {work[14:0], ~line};
    end
  end

  // Publish the completed word only when the sequencer commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= work;
    end
  end

endmodule

// File: rtl/joy_autoread.sv
// SNES controller-port controller: drives latch and per-port clocks,
// runs the vblank auto-joypad read into JOY1..JOY4, and passes manual CPU
// port accesses through when no auto-read is in progress.
module joy_autoread
  import snes_joy_pkg::*;
#(
  parameter int unsigned LATCH_TICKS = DEF_LATCH_TICKS,
  parameter int unsigned HALF_TICKS  = DEF_HALF_TICKS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        ENABLE,
  input  logic        VBLANK_START,
  input  logic        MAN_LATCH,
  input  logic        MAN_CLK1,
  input  logic        MAN_CLK2,
  input  logic [1:0]  P1_DI,
  input  logic [1:0]  P2_DI,
  output logic        PORT_LATCH,
  output logic        P1_CLK,
  output logic        P2_CLK,
  output logic [15:0] JOY1,
  output logic [15:0] JOY2,
  output logic [15:0] JOY3,
  output logic [15:0] JOY4,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned TICK_W = tick_width(LATCH_TICKS, HALF_TICKS);
  localparam logic [TICK_W-1:0] LAST_LATCH = TICK_W'(LATCH_TICKS - 1);
  localparam logic [TICK_W-1:0] LAST_HALF  = TICK_W'(HALF_TICKS - 1);

  joy_state_t        state;
  logic [TICK_W-1:0] tick;
  logic [BIT_W-1:0]  bit_idx;
  logic              shift_en;
  logic              load_en;

  // Sample the pads on the last low tick, just before the clocks rise;
  // copy working words out during the commit cycle.
  always_comb begin
    shift_en = (state == LO) && CE && (tick == LAST_HALF);
    load_en  = (state == COMMIT);
  end

  // Sequencer: manual pass-through in IDLE, timed latch/clock train while
  // busy. Every port strobe is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      PORT_LATCH <= 1'b0;
      P1_CLK     <= 1'b0;
      P2_CLK     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          PORT_LATCH <= MAN_LATCH;
          P1_CLK     <= MAN_CLK1;
          P2_CLK     <= MAN_CLK2;
          // Vblank start is a single-CLK strobe, so it is taken regardless of CE.
          if (VBLANK_START && ENABLE) begin
            state      <= LATCH;
            BUSY       <= 1'b1;
            tick       <= '0;
            PORT_LATCH <= 1'b1;
            P1_CLK     <= 1'b0;
            P2_CLK     <= 1'b0;
          end
        end

        LATCH: begin
          if (CE) begin
            if (tick == LAST_LATCH) begin
              PORT_LATCH <= 1'b0;
              tick       <= '0;
              bit_idx    <= '0;
              state      <= LO;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end

        LO: begin
          if (CE) begin
            if (tick == LAST_HALF) begin
              P1_CLK <= 1'b1;
              P2_CLK <= 1'b1;
              tick   <= '0;
              state  <= HI;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end

        HI: begin
          if (CE) begin
            if (tick == LAST_HALF) begin
              P1_CLK <= 1'b0;
              P2_CLK <= 1'b0;
              tick   <= '0;
              if (bit_idx != '1) begin
                bit_idx <= bit_idx + BIT_W'(1);
                state   <= LO;
              end else begin
                state <= COMMIT;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end

        COMMIT: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // JOY1 = P1 d0, JOY2 = P2 d0, JOY3 = P1 d1, JOY4 = P2 d1.
  joy_shift16 u_joy1 (
    .clk   (CLK),
    .rst   (RST),
    .shift (shift_en),
    .line  (P1_DI[0]),
    .load  (load_en),
    .q     (JOY1)
  );

  joy_shift16 u_joy2 (
    .clk   (CLK),
    .rst   (RST),
    .shift (shift_en),
    .line  (P2_DI[0]),
    .load  (load_en),
    .q     (JOY2)
  );

  joy_shift16 u_joy3 (
    .clk   (CLK),
    .rst   (RST),
    .shift (shift_en),
    .line  (P1_DI[1]),
    .load  (load_en),
    .q     (JOY3)
  );

  joy_shift16 u_joy4 (
    .clk   (CLK),
    .rst   (RST),
    .shift (shift_en),
    .line  (P2_DI[1]),
    .load  (load_en),
    .q     (JOY4)
  );

endmodule

// File: tb/tb_joy_autoread.sv
// Self-checking bench for joy_autoread with a behavioural pad model.
module tb_joy_autoread;

  localparam int LATCH_T = 12;
  localparam int HALF_T  = 6;

  logic        clk = 1'b0;
  logic        RST, CE, ENABLE, VBLANK_START;
  logic        MAN_LATCH, MAN_CLK1, MAN_CLK2;
  logic [1:0]  P1_DI, P2_DI;
  logic        PORT_LATCH, P1_CLK, P2_CLK, BUSY, DONE;
  logic [15:0] JOY1, JOY2, JOY3, JOY4;

  int total = 0;
  int bad   = 0;

  // Pad contents in JOY order, pressed=1; expected visible registers.
  logic [15:0] pat  [4];
  logic [15:0] jexp [4];
  int p1_idx = 16;
  int p2_idx = 16;
  logic p1_prev = 1'b0;
  logic p2_prev = 1'b0;

  joy_autoread #(.LATCH_TICKS(LATCH_T), .HALF_TICKS(HALF_T)) dut (
    .CLK(clk), .RST(RST), .CE(CE), .ENABLE(ENABLE),
    .VBLANK_START(VBLANK_START), .MAN_LATCH(MAN_LATCH),
    .MAN_CLK1(MAN_CLK1), .MAN_CLK2(MAN_CLK2),
    .P1_DI(P1_DI), .P2_DI(P2_DI), .PORT_LATCH(PORT_LATCH),
    .P1_CLK(P1_CLK), .P2_CLK(P2_CLK), .JOY1(JOY1), .JOY2(JOY2),
    .JOY3(JOY3), .JOY4(JOY4), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  function automatic logic pbit(input logic [15:0] v, input int idx);
    if (idx >= 16) return 1'b0;
    return v[15 - idx];
  endfunction

  function automatic logic [15:0] joy_of(input int k);
    case (k)
      0: return JOY1;
      1: return JOY2;
      2: return JOY3;
      default: return JOY4;
    endcase
  endfunction

  // Pad shift registers: latch reloads bit 15 (B), each clock rise advances.
  initial begin
    P1_DI = 2'b11;
    P2_DI = 2'b11;
    forever begin
      @(negedge clk);
      if (PORT_LATCH) p1_idx = 0;
      else if (P1_CLK && !p1_prev && p1_idx < 16) p1_idx++;
      if (PORT_LATCH) p2_idx = 0;
      else if (P2_CLK && !p2_prev && p2_idx < 16) p2_idx++;
      p1_prev = P1_CLK;
      p2_prev = P2_CLK;
      P1_DI = {~pbit(pat[2], p1_idx), ~pbit(pat[0], p1_idx)};
      P2_DI = {~pbit(pat[3], p2_idx), ~pbit(pat[1], p2_idx)};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    total++;
    if ({PORT_LATCH, P1_CLK, P2_CLK, BUSY, DONE} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {PORT_LATCH, P1_CLK, P2_CLK, BUSY, DONE});
    end
    total++;
    if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) begin
      bad++;
      $display("FAIL reset_joy: got %h want 0", {JOY1, JOY2, JOY3, JOY4});
    end
    RST = 1'b0;
    for (int k = 0; k < 4; k++) jexp[k] = 16'h0000;
    step();
  endtask

  // One full auto-read from the vblank strobe to a few cycles past DONE.
  task automatic run_read(input bit ce_rand, input bit disturb);
    int lat_ticks = 0, rises = 0, lo_run = 0, hi_run = 0, bad_runs = 0;
    int p2_diff = 0, overlap = 0, busy_cyc = 0, done_cnt = 0;
    int joy_moved = 0, after_done = 0;
    bit ce_now, prev_clk = 1'b0, seen_done = 1'b0;
    ENABLE = 1'b1;
    VBLANK_START = 1'b1;
    CE = ce_rand ? 1'b0 : 1'b1;
    step();
    VBLANK_START = 1'b0;
    check_int("busy_rise", int'(BUSY), 1);
    for (int cyc = 0; cyc < 3000 && after_done < 3; cyc++) begin
      ce_now = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      CE = ce_now;
      if (disturb && BUSY) begin
        VBLANK_START = ($urandom_range(0, 7) == 0);
        ENABLE    = $urandom_range(0, 1) != 0;
        MAN_LATCH = $urandom_range(0, 1) != 0;
        MAN_CLK1  = $urandom_range(0, 1) != 0;
        MAN_CLK2  = $urandom_range(0, 1) != 0;
      end else begin
        VBLANK_START = 1'b0;
        MAN_LATCH = 1'b0;
        MAN_CLK1  = 1'b0;
        MAN_CLK2  = 1'b0;
      end
      if (BUSY) busy_cyc++;
      if (PORT_LATCH && ce_now) lat_ticks++;
      if (PORT_LATCH && (P1_CLK || P2_CLK)) overlap++;
      if (P1_CLK !== P2_CLK) p2_diff++;
      if (BUSY && !PORT_LATCH) begin
        if (P1_CLK && !prev_clk) begin
          rises++;
          if (lo_run != HALF_T) bad_runs++;
          lo_run = 0;
        end
        if (!P1_CLK && prev_clk) begin
          if (hi_run != HALF_T) bad_runs++;
          hi_run = 0;
        end
        if (ce_now) begin
          if (P1_CLK) hi_run++;
          else lo_run++;
        end
      end
      prev_clk = P1_CLK;
      if (BUSY) begin
        for (int k = 0; k < 4; k++)
          if (joy_of(k) !== jexp[k]) joy_moved++;
      end
      if (DONE) begin
        done_cnt++;
        if (!seen_done) begin
          for (int k = 0; k < 4; k++) begin
            total++;
            if (joy_of(k) !== pat[k]) begin
              bad++;
              $display("FAIL joy%0d_commit: got %h want %h", k + 1, joy_of(k), pat[k]);
            end
            jexp[k] = pat[k];
          end
        end
        seen_done = 1'b1;
      end
      if (seen_done) after_done++;
      step();
    end
    check_int("done_seen", int'(seen_done), 1);
    check_int("latch_ticks", lat_ticks, LATCH_T);
    check_int("clk_pulses", rises, 16);
    check_int("bad_half_phases", bad_runs, 0);
    check_int("clk_during_latch", overlap, 0);
    check_int("p1_p2_clk_differ", p2_diff, 0);
    check_int("done_pulses", done_cnt, 1);
    check_int("joy_moved_while_busy", joy_moved, 0);
    if (!ce_rand) check_int("busy_cycles", busy_cyc, LATCH_T + 32 * HALF_T + 1);
    // Ports are back under manual control right after commit.
    ENABLE = 1'b0;
    CE = 1'b1;
    MAN_LATCH = 1'b1;
    step();
    check_int("man_latch_follow_hi", int'(PORT_LATCH), 1);
    MAN_LATCH = 1'b0;
    step();
    check_int("man_latch_follow_lo", int'(PORT_LATCH), 0);
  endtask

  task automatic test_auto_read_timing();
    pat[0] = 16'h8000;
    pat[1] = 16'h0000;
    pat[2] = 16'h0000;
    pat[3] = 16'h0F0F;
    run_read(1'b0, 1'b0);
  endtask

  task automatic test_random_reads();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) pat[k] = 16'($urandom);
      run_read(1'b1, 1'b0);
    end
  endtask

  task automatic test_mid_read_disturb();
    for (int k = 0; k < 4; k++) pat[k] = 16'($urandom);
    run_read(1'b0, 1'b1);
  endtask

  task automatic test_manual_idle();
    int rises = 0, lat_err = 0, p2_err = 0, latch_err = 0, joy_err = 0;
    logic prev = 1'b0;
    CE = 1'b0;
    MAN_LATCH = 1'b1;
    MAN_CLK1 = 1'b0;
    step();
    check_int("man_latch_on", int'(PORT_LATCH), 1);
    for (int i = 0; i < 6; i++) begin
      MAN_CLK1 = ~MAN_CLK1;
      step();
      if (P1_CLK !== MAN_CLK1) lat_err++;
      if (P1_CLK && !prev) rises++;
      prev = P1_CLK;
      if (P2_CLK !== 1'b0) p2_err++;
      if (PORT_LATCH !== 1'b1) latch_err++;
      for (int k = 0; k < 4; k++)
        if (joy_of(k) !== jexp[k]) joy_err++;
    end
    check_int("man_clk1_rises", rises, 3);
    check_int("man_clk1_latency_err", lat_err, 0);
    check_int("man_p2_clk_active", p2_err, 0);
    check_int("man_latch_dropped", latch_err, 0);
    check_int("man_joy_changed", joy_err, 0);
    MAN_LATCH = 1'b0;
    CE = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_read();
    int rises = 0;
    logic prev = 1'b0;
    for (int k = 0; k < 4; k++) pat[k] = 16'($urandom) | 16'h0001;
    ENABLE = 1'b1;
    CE = 1'b1;
    VBLANK_START = 1'b1;
    step();
    VBLANK_START = 1'b0;
    for (int c = 0; c < 400 && rises < 8; c++) begin
      if (P1_CLK && !prev) rises++;
      prev = P1_CLK;
      if (rises < 8) step();
    end
    check_int("reached_bit7_hi", rises, 8);
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if ({PORT_LATCH, P1_CLK, P2_CLK, BUSY, DONE} !== 5'b0) begin
      bad++;
      $display("FAIL midreset_ctrl: got %b want 00000",
               {PORT_LATCH, P1_CLK, P2_CLK, BUSY, DONE});
    end
    total++;
    if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) begin
      bad++;
      $display("FAIL midreset_joy: got %h want 0", {JOY1, JOY2, JOY3, JOY4});
    end
    for (int k = 0; k < 4; k++) jexp[k] = 16'h0000;
    step();
    for (int k = 0; k < 4; k++) pat[k] = 16'($urandom);
    run_read(1'b0, 1'b0);
  endtask

  task automatic test_disabled();
    int act = 0, moved = 0;
    for (int k = 0; k < 4; k++) pat[k] = 16'($urandom);
    ENABLE = 1'b0;
    CE = 1'b1;
    VBLANK_START = 1'b1;
    step();
    VBLANK_START = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (BUSY || PORT_LATCH || P1_CLK || P2_CLK || DONE) act++;
      for (int k = 0; k < 4; k++)
        if (joy_of(k) !== jexp[k]) moved++;
      step();
    end
    check_int("disabled_activity", act, 0);
    check_int("disabled_joy_changed", moved, 0);
  endtask

  initial begin
    RST = 1'b1;
    CE = 1'b0;
    ENABLE = 1'b0;
    VBLANK_START = 1'b0;
    MAN_LATCH = 1'b0;
    MAN_CLK1 = 1'b0;
    MAN_CLK2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pat[k] = 16'h0000;
      jexp[k] = 16'h0000;
    end
    test_reset();
    test_auto_read_timing();
    test_random_reads();
    test_mid_read_disturb();
    test_manual_idle();
    test_reset_mid_read();
    test_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
